// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: opcode classes, access widths, memory-stage FSM
// states and the access-decode helpers used by the memory stage.
package rv32_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_STORE  = 2'b01;
    localparam logic [1:0] OP_BRANCH = 2'b10;
    localparam logic [1:0] OP_JUMP   = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_ERR
    } mem_state_t;

    // Reserved widths (and unsigned widths on stores) are rejected like misalignment.
    function automatic logic access_misaligned(input logic is_store, input logic [2:0] funct3,
                                               input logic [1:0] offset);
        case (funct3)
            F3_B:    return 1'b0;
            F3_H:    return offset[0];
            F3_W:    return offset != 2'b00;
            F3_BU:   return is_store;
            F3_HU:   return is_store | offset[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic is_store, input logic [2:0] funct3,
                                               input logic [1:0] offset);
        if (!is_store) return 4'b1111;
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load-data formatter: picks the byte/halfword at the access offset and sign- or
// zero-extends it; full words pass through.
module load_align
    import rv32_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        case (offset)
            2'b00:   sel_byte = word[7:0];
            2'b01:   sel_byte = word[15:8];
            2'b10:   sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
            F3_H:    data = {{16{sel_half[15]}}, sel_half};
            F3_BU:   data = {24'h0, sel_byte};
            F3_HU:   data = {16'h0, sel_half};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/pipeline_mem.sv
// RV32I memory-access stage: issues one load/store at a time on a req/ack port,
// stalls the pipeline while it is outstanding and formats load data for writeback.
module pipeline_mem
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [5:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] alu_out_i,
    input  logic [31:0] rs2_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic [31:0] dmem_data_o,
    output logic        stall_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    mem_state_t  state, state_next;
    logic        mem_op, is_store, misaligned, timeout;
    logic [2:0]  fmt_funct3;
    logic [1:0]  fmt_offset;
    logic [31:0] load_word, aligned, data_hold;
    logic [7:0]  wait_cnt;
    logic        unused_opcode_bits;

    assign unused_opcode_bits = ^opcode_i[2:0];

    assign is_store   = opcode_i[4:3] == OP_STORE;
    assign mem_op     = valid_i & opcode_i[5] & ((opcode_i[4:3] == OP_LOAD) | is_store);
    assign misaligned = access_misaligned(is_store, funct3_i, alu_out_i[1:0]);
    // Ack in the final wait cycle takes priority over the timeout.
    assign timeout    = (state == ST_WAIT) & ~dmem_ack_i & (wait_cnt == LAST_WAIT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mem_op) state_next = misaligned ? ST_ERR : ST_WAIT;
            ST_WAIT: if (dmem_ack_i || timeout) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            ST_ERR:  state_next = ST_RESP;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            fmt_funct3   <= '0;
            fmt_offset   <= '0;
            load_word    <= '0;
            data_hold    <= '0;
            bus_err_o    <= 1'b0;
        end else begin
            state     <= state_next;
            bus_err_o <= timeout;
            case (state)
                ST_IDLE: begin
                    if (mem_op && !misaligned) begin
                        dmem_we_o    <= is_store;
                        dmem_addr_o  <= {alu_out_i[31:2], 2'b00};
                        dmem_be_o    <= byte_enable(is_store, funct3_i, alu_out_i[1:0]);
                        dmem_wdata_o <= store_lanes(funct3_i, rs2_data_i);
                        fmt_funct3   <= funct3_i;
                        fmt_offset   <= alu_out_i[1:0];
                        wait_cnt     <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ack_i) begin
                        if (!dmem_we_o) load_word <= dmem_rdata_i;
                    end else if (timeout) begin
                        load_word <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_ERR:  load_word <= '0;
                ST_RESP: data_hold <= aligned;
                default: ;
            endcase
        end
    end

    load_align u_load_align (
        .word   (load_word),
        .funct3 (fmt_funct3),
        .offset (fmt_offset),
        .data   (aligned)
    );

    assign dmem_req_o  = state == ST_WAIT;
    assign misalign_o  = state == ST_ERR;
    assign stall_o     = ((state != ST_IDLE) & (state != ST_RESP)) | ((state == ST_IDLE) & mem_op);
    assign dmem_data_o = (state == ST_RESP) ? aligned : data_hold;

endmodule
